// File: rtl/drive_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : drive_ram_arbiter_pkg
// Brief   : Shared types and constants for the drive RAM read arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package drive_ram_arbiter_pkg;

    localparam int DRIVE_RAM_TIMEOUT_DEFAULT = 255;
    localparam int DRIVE_RAM_DATA_W          = 32;
    localparam int DRIVE_RAM_CNT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Next client index in round-robin order, wrapping at n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drive_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : drive_ram_arbiter_if
// Brief   : Client request/response and SDRAM port bundle for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface drive_ram_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 21
);
    logic [NUM_CLIENTS-1:0]             rd_i;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr_i;
    logic [NUM_CLIENTS-1:0][31:0]       q_o;
    logic [NUM_CLIENTS-1:0]             ack_o;
    logic [NUM_CLIENTS-1:0]             err_o;
    logic [ADDR_W-1:0]                  mem_addr_o;
    logic                               mem_rd_o;
    logic                               mem_ready_i;
    logic [31:0]                        mem_q_i;
    logic                               mem_valid_i;
    logic                               busy_o;

    // Arbiter side
    modport slave (
        input  rd_i, addr_i, mem_ready_i, mem_q_i, mem_valid_i,
        output q_o, ack_o, err_o, mem_addr_o, mem_rd_o, busy_o
    );

    // Clients plus SDRAM side
    modport master (
        output rd_i, addr_i, mem_ready_i, mem_q_i, mem_valid_i,
        input  q_o, ack_o, err_o, mem_addr_o, mem_rd_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/drive_ram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker; one-hot grant after last_i.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import drive_ram_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int CLIENT_W    = 1
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [CLIENT_W-1:0]    last_i,
    output logic [NUM_CLIENTS-1:0] grant_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        idx     = int'(last_i);
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = rr_next(idx, NUM_CLIENTS);
            if (req_i[idx] && (grant_o == '0)) begin
                grant_o[idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/drive_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : drive_ram_arbiter
// Brief   : Multi-client SDRAM read arbiter with per-client one-entry cache.
// Revision: 1.0 - initial release
// ============================================================================
module drive_ram_arbiter
    import drive_ram_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 21,
    parameter int TIMEOUT     = DRIVE_RAM_TIMEOUT_DEFAULT
) (
    input  logic                clk_logic,
    input  logic                system_reset,
    drive_ram_arbiter_if.slave  bus
);

    localparam int CLIENT_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [DRIVE_RAM_CNT_W-1:0] TIMEOUT_LAST = DRIVE_RAM_CNT_W'(TIMEOUT - 1);
    localparam logic [CLIENT_W-1:0]        LAST_RESET   = CLIENT_W'(NUM_CLIENTS - 1);

    arb_state_e                          state_q, state_d;
    logic [NUM_CLIENTS-1:0]              pend_q, pend_d;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  paddr_q, paddr_d;
    logic [NUM_CLIENTS-1:0]              cval_q, cval_d;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  caddr_q, caddr_d;
    logic [NUM_CLIENTS-1:0][31:0]        data_q, data_d;
    logic [NUM_CLIENTS-1:0]              ack_q, ack_d;
    logic [NUM_CLIENTS-1:0]              err_q, err_d;
    logic                                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]                   mem_addr_q, mem_addr_d;
    logic [DRIVE_RAM_CNT_W-1:0]          cnt_q, cnt_d;
    logic [CLIENT_W-1:0]                 last_q, last_d;

    logic [NUM_CLIENTS-1:0]              rd_hit;
    logic [NUM_CLIENTS-1:0]              pend_hit;
    logic [NUM_CLIENTS-1:0]              arb_req;
    logic [NUM_CLIENTS-1:0]              arb_grant;
    logic [CLIENT_W-1:0]                 gnt_idx;

    // A pending address can become a hit when an in-flight fetch of the
    // same client lands on it; those complete locally instead of re-fetching.
    always_comb begin
        rd_hit   = '0;
        pend_hit = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            rd_hit[c]   = bus.rd_i[c] && cval_q[c] && (bus.addr_i[c] == caddr_q[c]);
            pend_hit[c] = pend_q[c] && cval_q[c] && (paddr_q[c] == caddr_q[c]);
        end
    end

    assign arb_req = pend_q & ~pend_hit;

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .CLIENT_W    (CLIENT_W)
    ) u_rr (
        .req_i   (arb_req),
        .last_i  (last_q),
        .grant_o (arb_grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (arb_grant[c]) begin
                gnt_idx = CLIENT_W'(c);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        paddr_d    = paddr_q;
        cval_d     = cval_q;
        caddr_d    = caddr_q;
        data_d     = data_q;
        ack_d      = '0;
        err_d      = err_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;

        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (pend_hit[c]) begin
                ack_d[c]  = 1'b1;
                pend_d[c] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|arb_req) begin
                    state_d          = ST_ISSUE;
                    last_d           = gnt_idx;
                    mem_rd_d         = 1'b1;
                    mem_addr_d       = paddr_q[gnt_idx];
                    pend_d[gnt_idx]  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ready_i) begin
                    state_d  = ST_WAIT;
                    mem_rd_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            ST_WAIT: begin
                if (bus.mem_valid_i) begin
                    state_d         = ST_IDLE;
                    data_d[last_q]  = bus.mem_q_i;
                    cval_d[last_q]  = 1'b1;
                    caddr_d[last_q] = mem_addr_q;
                    ack_d[last_q]   = 1'b1;
                    err_d[last_q]   = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d         = ST_IDLE;
                    cval_d[last_q]  = 1'b0;
                    ack_d[last_q]   = 1'b1;
                    err_d[last_q]   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // New requests are applied last so they override the grant-time
        // clear; a request arriving mid-flight re-arbitrates afterwards.
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (bus.rd_i[c]) begin
                if (rd_hit[c]) begin
                    ack_d[c]  = 1'b1;
                    pend_d[c] = 1'b0;
                end else begin
                    pend_d[c]  = 1'b1;
                    paddr_d[c] = bus.addr_i[c];
                end
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            paddr_q    <= '0;
            cval_q     <= '0;
            caddr_q    <= '0;
            data_q     <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            last_q     <= LAST_RESET;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            paddr_q    <= paddr_d;
            cval_q     <= cval_d;
            caddr_q    <= caddr_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign bus.q_o        = data_q;
    assign bus.ack_o      = ack_q;
    assign bus.err_o      = err_q;
    assign bus.mem_rd_o   = mem_rd_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.busy_o     = (state_q != ST_IDLE) || (|pend_q);

endmodule
`default_nettype wire

// File: tb/tb_drive_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_drive_ram_arbiter
// Brief   : Directed and randomized bench with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_drive_ram_arbiter;

    localparam int NC = 3;
    localparam int AW = 21;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drive_ram_arbiter_if #(.NUM_CLIENTS(NC), .ADDR_W(AW)) bus ();

    drive_ram_arbiter #(
        .NUM_CLIENTS (NC),
        .ADDR_W      (AW),
        .TIMEOUT     (TO)
    ) dut (
        .clk_logic    (clk),
        .system_reset (rst),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // ---------------- transaction-level reference model ----------------
    int              cyc = 0;
    bit              m_pend [NC];
    logic [AW-1:0]   m_pa   [NC];
    bit              m_cv   [NC];
    logic [AW-1:0]   m_ca   [NC];
    logic [31:0]     m_q    [NC];
    bit              m_ack  [NC];
    bit              m_err  [NC];
    bit              m_inflight, m_acc;
    int              m_cli, m_last, m_acc_cyc;
    logic [AW-1:0]   m_addr;

    always @(posedge clk) begin
        bit            old_cv [NC];
        logic [AW-1:0] old_ca [NC];
        int            pick;
        cyc++;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_pend[c] = 0; m_pa[c] = '0; m_cv[c] = 0; m_ca[c] = '0;
                m_q[c] = '0; m_ack[c] = 0; m_err[c] = 0;
            end
            m_inflight = 0; m_acc = 0; m_cli = 0; m_last = NC - 1; m_addr = '0; m_acc_cyc = 0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                old_cv[c] = m_cv[c];
                old_ca[c] = m_ca[c];
                m_ack[c]  = 0;
                if (m_pend[c] && m_cv[c] && m_pa[c] == m_ca[c]) begin
                    m_ack[c] = 1; m_pend[c] = 0;
                end
            end
            if (!m_inflight) begin
                pick = -1;
                for (int k = 1; k <= NC; k++) begin
                    if (pick < 0 && m_pend[(m_last + k) % NC]) pick = (m_last + k) % NC;
                end
                if (pick >= 0) begin
                    m_inflight = 1; m_acc = 0; m_cli = pick; m_last = pick;
                    m_addr = m_pa[pick]; m_pend[pick] = 0;
                end
            end else if (!m_acc) begin
                if (bus.mem_ready_i) begin
                    m_acc = 1; m_acc_cyc = cyc;
                end
            end else if (bus.mem_valid_i) begin
                m_q[m_cli] = bus.mem_q_i; m_cv[m_cli] = 1; m_ca[m_cli] = m_addr;
                m_ack[m_cli] = 1; m_err[m_cli] = 0; m_inflight = 0;
            end else if (cyc - m_acc_cyc == TO) begin
                m_err[m_cli] = 1; m_cv[m_cli] = 0; m_ack[m_cli] = 1; m_inflight = 0;
            end
            for (int c = 0; c < NC; c++) begin
                if (bus.rd_i[c]) begin
                    if (old_cv[c] && bus.addr_i[c] == old_ca[c]) begin
                        m_ack[c] = 1; m_pend[c] = 0;
                    end else begin
                        m_pend[c] = 1; m_pa[c] = bus.addr_i[c];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit any_pend;
        if (cmp_en) begin
            any_pend = 0;
            for (int c = 0; c < NC; c++) begin
                check($sformatf("q_o[%0d]", c), 64'(bus.q_o[c]), 64'(m_q[c]));
                check($sformatf("ack_o[%0d]", c), 64'(bus.ack_o[c]), 64'(m_ack[c]));
                check($sformatf("err_o[%0d]", c), 64'(bus.err_o[c]), 64'(m_err[c]));
                any_pend |= m_pend[c];
            end
            check("mem_rd_o", 64'(bus.mem_rd_o), 64'(m_inflight && !m_acc));
            check("mem_addr_o", 64'(bus.mem_addr_o), 64'(m_addr));
            check("busy_o", 64'(bus.busy_o), 64'(m_inflight || any_pend));
        end
    end

    // ---------------- SDRAM responder ----------------
    bit          rsp_random  = 0;
    int          ready_delay = 0;
    int          valid_delay = 3;
    int          vcnt = 0;
    int          rcnt = 0;
    logic [31:0] rsp_data;

    always @(negedge clk) begin
        if (rsp_random) begin
            bus.mem_ready_i = 1'($urandom_range(0, 1));
            bus.mem_valid_i = ($urandom_range(0, 5) == 0);
            bus.mem_q_i     = $urandom;
        end else begin
            bus.mem_valid_i = 1'b0;
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) begin
                    bus.mem_valid_i = 1'b1;
                    bus.mem_q_i     = rsp_data;
                    rsp_data++;
                end
            end
            if (bus.mem_rd_o) begin
                if (rcnt < ready_delay) begin
                    bus.mem_ready_i = 1'b0;
                    rcnt++;
                end else begin
                    bus.mem_ready_i = 1'b1;
                end
            end else begin
                bus.mem_ready_i = 1'b0;
                rcnt = 0;
            end
            if (bus.mem_rd_o && bus.mem_ready_i) begin
                rcnt = 0;
                if (valid_delay > 0) vcnt = valid_delay;
            end
        end
    end

    // ---------------- event counters for directed checks ----------------
    int rd_cycles;
    int ack_cnt [NC];

    always @(posedge clk) begin
        #2;
        if (bus.mem_rd_o) rd_cycles++;
        for (int c = 0; c < NC; c++) ack_cnt[c] += int'(bus.ack_o[c]);
    end

    task automatic clear_counts;
        rd_cycles = 0;
        for (int c = 0; c < NC; c++) ack_cnt[c] = 0;
    endtask

    task automatic request(input int c, input logic [AW-1:0] a);
        bus.rd_i[c]   = 1'b1;
        bus.addr_i[c] = a;
        tick;
        bus.rd_i = '0;
    endtask

    task automatic wait_rd(input logic lvl);
        int n = 0;
        while (bus.mem_rd_o !== lvl && n < 100) begin
            tick;
            n++;
        end
        check("wait_mem_rd", 64'(bus.mem_rd_o), 64'(lvl));
    endtask

    task automatic wait_idle;
        int n = 0;
        while (bus.busy_o !== 1'b0 && n < 200) begin
            tick;
            n++;
        end
        check("wait_idle", 64'(bus.busy_o), 64'd0);
    endtask

    logic [AW-1:0] pool [4] = '{21'h10, 21'h20, 21'h1FFFFF, 21'h0};

    initial begin
        bit stable;
        rst = 1'b1;
        bus.rd_i = '0;
        bus.addr_i = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.mem_q_i = '0;
        rsp_data = 32'hA1B2C3D4;
        clear_counts();
        repeat (3) tick;
        cmp_en = 1'b1;

        // reset state
        check("rst_q_o", 64'(bus.q_o), 64'd0);
        check("rst_ack_o", 64'(bus.ack_o), 64'd0);
        check("rst_err_o", 64'(bus.err_o), 64'd0);
        check("rst_mem_rd_o", 64'(bus.mem_rd_o), 64'd0);
        check("rst_mem_addr_o", 64'(bus.mem_addr_o), 64'd0);
        check("rst_busy_o", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        tick;

        // single fetch, data three cycles after acceptance
        clear_counts();
        request(0, 21'h10040);
        wait_idle();
        check("fetch_rd_cycles", 64'(rd_cycles), 64'd1);
        check("fetch_ack_cnt", 64'(ack_cnt[0]), 64'd1);
        check("fetch_q0", 64'(bus.q_o[0]), 64'hA1B2C3D4);

        // cache hit acknowledges next cycle without SDRAM access
        clear_counts();
        bus.rd_i[0] = 1'b1;
        bus.addr_i[0] = 21'h10040;
        tick;
        bus.rd_i = '0;
        check("hit_ack0", 64'(bus.ack_o[0]), 64'd1);
        check("hit_mem_rd", 64'(bus.mem_rd_o), 64'd0);
        repeat (5) tick;
        check("hit_rd_cycles", 64'(rd_cycles), 64'd0);
        check("hit_ack_cnt", 64'(ack_cnt[0]), 64'd1);

        // simultaneous requests, last grant was client 0
        clear_counts();
        rsp_data = 32'h11110001;
        valid_delay = 2;
        bus.addr_i[0] = 21'h200;
        bus.addr_i[1] = 21'h300;
        bus.rd_i = 3'b011;
        tick;
        bus.rd_i = '0;
        wait_rd(1'b1);
        check("rr_first_addr", 64'(bus.mem_addr_o), 64'h300);
        wait_rd(1'b0);
        wait_rd(1'b1);
        check("rr_second_addr", 64'(bus.mem_addr_o), 64'h200);
        wait_idle();
        check("rr_rd_cycles", 64'(rd_cycles), 64'd2);
        check("rr_ack0", 64'(ack_cnt[0]), 64'd1);
        check("rr_ack1", 64'(ack_cnt[1]), 64'd1);
        check("rr_q1", 64'(bus.q_o[1]), 64'h11110001);
        check("rr_q0", 64'(bus.q_o[0]), 64'h11110002);

        // SDRAM back-pressure for 20 cycles
        clear_counts();
        ready_delay = 20;
        rsp_data = 32'h35353535;
        request(0, 21'h400);
        wait_rd(1'b1);
        stable = 1'b1;
        repeat (20) begin
            if (!(bus.mem_rd_o === 1'b1 && bus.mem_addr_o === 21'h400)) stable = 1'b0;
            tick;
        end
        check("bp_stable", 64'(stable), 64'd1);
        wait_idle();
        ready_delay = 0;
        check("bp_rd_cycles", 64'(rd_cycles), 64'd21);
        check("bp_q0", 64'(bus.q_o[0]), 64'h35353535);

        // timeout on client 1
        valid_delay = 0;
        request(1, 21'h500);
        wait_rd(1'b1);
        repeat (8) tick;
        check("to_early_ack1", 64'(bus.ack_o[1]), 64'd0);
        tick;
        check("to_ack1", 64'(bus.ack_o[1]), 64'd1);
        check("to_err1", 64'(bus.err_o[1]), 64'd1);
        check("to_q1", 64'(bus.q_o[1]), 64'h11110001);
        wait_idle();
        valid_delay = 2;
        rsp_data = 32'h36363636;
        request(1, 21'h500);
        wait_idle();
        check("recover_err1", 64'(bus.err_o[1]), 64'd0);
        check("recover_q1", 64'(bus.q_o[1]), 64'h36363636);

        // reset while waiting for data; late data ignored
        clear_counts();
        valid_delay = 4;
        request(0, 21'h600);
        wait_rd(1'b1);
        wait_rd(1'b0);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        repeat (8) tick;
        check("rstw_ack_cnt", 64'(ack_cnt[0]), 64'd0);
        check("rstw_q_o", 64'(bus.q_o), 64'd0);
        check("rstw_err_o", 64'(bus.err_o), 64'd0);
        check("rstw_busy_o", 64'(bus.busy_o), 64'd0);
        check("rstw_mem_rd_o", 64'(bus.mem_rd_o), 64'd0);
        check("rstw_mem_addr_o", 64'(bus.mem_addr_o), 64'd0);

        // randomized traffic against the model
        valid_delay = 0;
        vcnt = 0;
        rsp_random = 1'b1;
        repeat (4000) begin
            for (int c = 0; c < NC; c++) begin
                bus.rd_i[c]   = ($urandom_range(0, 7) == 0);
                bus.addr_i[c] = pool[$urandom_range(0, 3)];
            end
            rst = ($urandom_range(0, 599) == 0);
            tick;
        end
        bus.rd_i = '0;
        rst = 1'b0;
        rsp_random = 1'b0;
        valid_delay = 2;
        repeat (40) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
